spi_resp_slave: RTL

SPI_RESP_SLAVE -- requirements
Module: spi_resp_slave

---
 rtl/spi_resp_if.sv | 33 +++
 rtl/spi_resp_slave.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_resp_if.sv
// SPI command/response slave bus: serial pins, command/response status and FSM debug state.
// With XFER_COUNT_EN defined the bus also carries the completed-transfer counter.
interface spi_resp_if;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        miso;
    logic        response_ready;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        resp_sent;
    logic        abort;
    logic [2:0]  state_dbg;
`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    modport slave (
        input  sclk, mosi, cs_n,
        output miso, response_ready, cmd_data, cmd_valid, resp_sent, abort, state_dbg
`ifdef XFER_COUNT_EN
        , output xfer_count
`endif
    );

    modport master (
        output sclk, mosi, cs_n,
        input  miso, response_ready, cmd_data, cmd_valid, resp_sent, abort, state_dbg
`ifdef XFER_COUNT_EN
        , input xfer_count
`endif
    );
endinterface

// File: rtl/spi_resp_slave.sv
// SPI mode-0 slave: receives a 32-bit command, answers cmd + RESP_ADD after RESP_LATENCY clks.
// Optional feature macro XFER_COUNT_EN adds a 16-bit completed-response counter.
module spi_resp_slave #(
    parameter int unsigned RESP_LATENCY = 2,
    parameter logic [31:0] RESP_ADD     = 32'h0000_0001
) (
    input  logic       clk,
    input  logic       rst,
    spi_resp_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RX_CMD     = 3'd1,
        COMPUTE    = 3'd2,
        RESP_READY = 3'd3,
        TX_RESP    = 3'd4
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(RESP_LATENCY - 1);

    state_t      state_q, state_d;
    logic        sclk_d;
    logic        rise, fall;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  lat_q, lat_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] resp_q, resp_d;
    logic [31:0] cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        resp_sent_q, resp_sent_d;
    logic        abort_q, abort_d;

    assign rise = bus.sclk & ~sclk_d;
    assign fall = ~bus.sclk & sclk_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_d      <= 1'b0;
            cnt_q       <= '0;
            lat_q       <= '0;
            shreg_q     <= '0;
            resp_q      <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            resp_sent_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_d      <= bus.sclk;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            shreg_q     <= shreg_d;
            resp_q      <= resp_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            resp_sent_q <= resp_sent_d;
            abort_q     <= abort_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        shreg_d     = shreg_q;
        resp_d      = resp_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        resp_sent_d = 1'b0;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.cs_n) begin
                    state_d = RX_CMD;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            RX_CMD: begin
                // cs_n is checked first so a simultaneous sclk rise is dropped with the word
                if (bus.cs_n) begin
                    abort_d = (cnt_q != 6'd0);
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (rise) begin
                    shreg_d = {shreg_q[30:0], bus.mosi};
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        cmd_d       = {shreg_q[30:0], bus.mosi};
                        cmd_valid_d = 1'b1;
                        state_d     = COMPUTE;
                        lat_d       = '0;
                        cnt_d       = '0;
                    end
                end
            end
            COMPUTE: begin
                if (bus.cs_n) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (lat_q == LAT_LAST) begin
                    resp_d  = cmd_q + RESP_ADD;
                    state_d = RESP_READY;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RESP_READY: begin
                if (bus.cs_n) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (rise) begin
                    state_d = TX_RESP;
                    cnt_d   = 6'd1;
                end
            end
            TX_RESP: begin
                // A completed 32nd bit wins over a concurrent cs_n rise: the response was delivered
                if (rise && cnt_q == 6'd31) begin
                    resp_sent_d = 1'b1;
                    cnt_d       = '0;
                    shreg_d     = '0;
                    state_d     = bus.cs_n ? IDLE : RX_CMD;
                end else if (bus.cs_n) begin
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (fall) resp_d = {resp_q[30:0], 1'b0};
                    if (rise) cnt_d = cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.miso           = ((state_q == RESP_READY) || (state_q == TX_RESP)) ? resp_q[31] : 1'b0;
    assign bus.response_ready = (state_q == RESP_READY);
    assign bus.cmd_data       = cmd_q;
    assign bus.cmd_valid      = cmd_valid_q;
    assign bus.resp_sent      = resp_sent_q;
    assign bus.abort          = abort_q;
    assign bus.state_dbg      = state_q;

`ifdef XFER_COUNT_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= '0;
        end else if (resp_sent_q) begin
            xfer_count_q <= xfer_count_q + 16'd1;
        end
    end

    assign bus.xfer_count = xfer_count_q;
`endif
endmodule
